// File: rtl/cordic_pkg.sv
// Shared constants for the CORDIC engine: arctangent table, quadrant angles,
// mode encoding and the gain-compensation factor.
package cordic_pkg;

  typedef enum logic {
    MODE_ROT = 1'b0,
    MODE_VEC = 1'b1
  } mode_e;

  localparam logic [31:0] ANG_P90   = 32'h4000_0000;
  localparam logic [31:0] ANG_M90   = 32'hC000_0000;
  localparam int          INV_K_Q15 = 19898;

  // atan(2^-i) in binary angle units, full circle = 2^32, rounded to nearest
  localparam logic [31:0] ATAN_TABLE [31] = '{
    32'h2000_0000, 32'h12E4_051E, 32'h09FB_385B, 32'h0511_11D4,
    32'h028B_0D43, 32'h0145_D7E1, 32'h00A2_F61E, 32'h0051_7C55,
    32'h0028_BE53, 32'h0014_5F2F, 32'h000A_2F98, 32'h0005_17CC,
    32'h0002_8BE6, 32'h0001_45F3, 32'h0000_A2FA, 32'h0000_517D,
    32'h0000_28BE, 32'h0000_145F, 32'h0000_0A30, 32'h0000_0518,
    32'h0000_028C, 32'h0000_0146, 32'h0000_00A3, 32'h0000_0051,
    32'h0000_0029, 32'h0000_0014, 32'h0000_000A, 32'h0000_0005,
    32'h0000_0003, 32'h0000_0001, 32'h0000_0001
  };

endpackage

// File: rtl/cordic_stage.sv
// One registered CORDIC micro-rotation; IDX selects the shift amount and the
// arctangent constant. The direction comes from sign(Z) or sign(Y) per sample mode.
module cordic_stage
  import cordic_pkg::*;
#(
  parameter int XY_SZ = 16,
  parameter int Z_SZ  = 32,
  parameter int IDX   = 0
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic                  src_valid,
  input  logic                  src_mode,
  input  logic signed [XY_SZ:0] src_x,
  input  logic signed [XY_SZ:0] src_y,
  input  logic [Z_SZ-1:0]       src_z,
  output logic                  valid,
  output logic                  mode,
  output logic signed [XY_SZ:0] x,
  output logic signed [XY_SZ:0] y,
  output logic [Z_SZ-1:0]       z
);

  localparam logic [Z_SZ-1:0] ATAN_I = Z_SZ'(ATAN_TABLE[IDX]);

  logic signed [XY_SZ:0] x_shift, y_shift;
  logic signed [XY_SZ:0] x_next, y_next;
  logic [Z_SZ-1:0]       z_next;
  logic                  dir;

  always_comb begin
    x_shift = src_x >>> IDX;
    y_shift = src_y >>> IDX;
    // dir=1 rotates clockwise: drives negative Z up in rotation, positive Y down in vectoring
    dir     = (src_mode == MODE_VEC) ? ~src_y[XY_SZ] : src_z[Z_SZ-1];
    x_next  = src_x;
    y_next  = src_y;
    z_next  = src_z;
    if (dir) begin
      x_next = src_x + y_shift;
      y_next = src_y - x_shift;
      z_next = src_z + ATAN_I;
    end else begin
      x_next = src_x - y_shift;
      y_next = src_y + x_shift;
      z_next = src_z - ATAN_I;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      mode  <= 1'b0;
      x     <= '0;
      y     <= '0;
      z     <= '0;
    end else begin
      valid <= src_valid;
      mode  <= src_mode;
      x     <= x_next;
      y     <= y_next;
      z     <= z_next;
    end
  end

endmodule

// File: rtl/cordic_engine.sv
// Pipelined rotation/vectoring CORDIC: quadrant pre-rotation, STG micro-rotation
// stages, and an optional 1/K output scaler enabled by CORDIC_GAIN_COMP_EN.
module cordic_engine
  import cordic_pkg::*;
#(
  parameter int XY_SZ = 16,
  parameter int STG   = 16,
  parameter int Z_SZ  = 32
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic                  mode,
  input  logic [Z_SZ-1:0]       angle,
  input  logic signed [XY_SZ:0] Xin,
  input  logic signed [XY_SZ:0] Yin,
  output logic                  out_valid,
  output logic                  out_mode,
  output logic signed [XY_SZ:0] Xout,
  output logic signed [XY_SZ:0] Yout,
  output logic [Z_SZ-1:0]       Zout
);

  logic                  run_reg;
  logic                  pre_valid_reg, pre_mode_reg;
  logic signed [XY_SZ:0] pre_x_reg, pre_y_reg, pre_x_next, pre_y_next;
  logic [Z_SZ-1:0]       pre_z_reg, pre_z_next;

  logic                  valid_pipe [STG+1];
  logic                  mode_pipe  [STG+1];
  logic signed [XY_SZ:0] x_pipe     [STG+1];
  logic signed [XY_SZ:0] y_pipe     [STG+1];
  logic [Z_SZ-1:0]       z_pipe     [STG+1];

  // Fold the input into the +-90 deg range the micro-rotations can converge over
  always_comb begin
    pre_x_next = Xin;
    pre_y_next = Yin;
    pre_z_next = angle;
    if (mode == MODE_VEC) begin
      pre_z_next = '0;
      if (Xin[XY_SZ]) begin
        if (!Yin[XY_SZ]) begin
          pre_x_next = Yin;
          pre_y_next = -Xin;
          pre_z_next = ANG_P90;
        end else begin
          pre_x_next = -Yin;
          pre_y_next = Xin;
          pre_z_next = ANG_M90;
        end
      end
    end else begin
      case (angle[Z_SZ-1:Z_SZ-2])
        2'b01: begin
          pre_x_next = -Yin;
          pre_y_next = Xin;
          pre_z_next = {2'b00, angle[Z_SZ-3:0]};
        end
        2'b10: begin
          pre_x_next = Yin;
          pre_y_next = -Xin;
          pre_z_next = {2'b11, angle[Z_SZ-3:0]};
        end
        default: ;
      endcase
    end
  end

  // run_reg stays low for the first edge after reset release so that sample is dropped
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      run_reg       <= 1'b0;
      pre_valid_reg <= 1'b0;
      pre_mode_reg  <= 1'b0;
      pre_x_reg     <= '0;
      pre_y_reg     <= '0;
      pre_z_reg     <= '0;
    end else begin
      run_reg       <= 1'b1;
      pre_valid_reg <= in_valid & run_reg;
      pre_mode_reg  <= mode;
      pre_x_reg     <= pre_x_next;
      pre_y_reg     <= pre_y_next;
      pre_z_reg     <= pre_z_next;
    end
  end

  assign valid_pipe[0] = pre_valid_reg;
  assign mode_pipe[0]  = pre_mode_reg;
  assign x_pipe[0]     = pre_x_reg;
  assign y_pipe[0]     = pre_y_reg;
  assign z_pipe[0]     = pre_z_reg;

  for (genvar gi = 0; gi < STG; gi++) begin : g_stage
    cordic_stage #(
      .XY_SZ (XY_SZ),
      .Z_SZ  (Z_SZ),
      .IDX   (gi)
    ) u_stage (
      .clock     (clock),
      .rst_n     (rst_n),
      .src_valid (valid_pipe[gi]),
      .src_mode  (mode_pipe[gi]),
      .src_x     (x_pipe[gi]),
      .src_y     (y_pipe[gi]),
      .src_z     (z_pipe[gi]),
      .valid     (valid_pipe[gi+1]),
      .mode      (mode_pipe[gi+1]),
      .x         (x_pipe[gi+1]),
      .y         (y_pipe[gi+1]),
      .z         (z_pipe[gi+1])
    );
  end

`ifdef CORDIC_GAIN_COMP_EN
  localparam int PW = XY_SZ + 18;
  localparam logic signed [PW-1:0] INV_K = PW'(INV_K_Q15);
  localparam logic signed [PW-1:0] HALF  = PW'(1 << 14);

  logic signed [PW-1:0]  x_prod, y_prod;
  logic signed [XY_SZ:0] x_gc_reg, y_gc_reg, x_gc_next, y_gc_next;
  logic [Z_SZ-1:0]       z_gc_reg;
  logic                  valid_gc_reg, mode_gc_reg;

  // Q1.15 multiply by 1/K with round-half-up
  always_comb begin
    x_prod    = PW'(x_pipe[STG]) * INV_K;
    y_prod    = PW'(y_pipe[STG]) * INV_K;
    x_gc_next = (XY_SZ+1)'((x_prod + HALF) >>> 15);
    y_gc_next = (XY_SZ+1)'((y_prod + HALF) >>> 15);
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      valid_gc_reg <= 1'b0;
      mode_gc_reg  <= 1'b0;
      x_gc_reg     <= '0;
      y_gc_reg     <= '0;
      z_gc_reg     <= '0;
    end else begin
      valid_gc_reg <= valid_pipe[STG];
      mode_gc_reg  <= mode_pipe[STG];
      x_gc_reg     <= x_gc_next;
      y_gc_reg     <= y_gc_next;
      z_gc_reg     <= z_pipe[STG];
    end
  end

  assign out_valid = valid_gc_reg;
  assign out_mode  = mode_gc_reg;
  assign Xout      = x_gc_reg;
  assign Yout      = y_gc_reg;
  assign Zout      = z_gc_reg;
`else
  assign out_valid = valid_pipe[STG];
  assign out_mode  = mode_pipe[STG];
  assign Xout      = x_pipe[STG];
  assign Yout      = y_pipe[STG];
  assign Zout      = z_pipe[STG];
`endif

endmodule

// File: tb/tb_cordic_engine.sv
// Self-checking bench for cordic_engine: directed quadrant cases, a random
// mixed-mode stream with bubbles, and a mid-stream reset, against a real-valued model.
module tb_cordic_engine;

  localparam int XY_SZ = 16;
  localparam int STG   = 16;
`ifdef CORDIC_GAIN_COMP_EN
  localparam int  LAT      = STG + 2;
  localparam bit  GAIN_ONE = 1'b1;
`else
  localparam int  LAT      = STG + 1;
  localparam bit  GAIN_ONE = 1'b0;
`endif
  localparam real PI     = 3.14159265358979323846;
  localparam real TOL_XY = STG / 2 + 2;

  logic                  clock = 1'b0;
  logic                  rst_n;
  logic                  in_valid;
  logic                  mode;
  logic [31:0]           angle;
  logic signed [XY_SZ:0] Xin, Yin;
  logic                  out_valid, out_mode;
  logic signed [XY_SZ:0] Xout, Yout;
  logic [31:0]           Zout;

  int  checks = 0;
  int  errors = 0;
  real gain;

  typedef struct {
    bit          valid;
    bit          mode;
    real         ex;
    real         ey;
    logic [31:0] ez;
    longint      ztol;
  } exp_t;

  exp_t exp_q[$];

  cordic_engine #(.XY_SZ(XY_SZ), .STG(STG), .Z_SZ(32)) dut (
    .clock     (clock),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .mode      (mode),
    .angle     (angle),
    .Xin       (Xin),
    .Yin       (Yin),
    .out_valid (out_valid),
    .out_mode  (out_mode),
    .Xout      (Xout),
    .Yout      (Yout),
    .Zout      (Zout)
  );

  always #5 clock = ~clock;

  task automatic chk_val(input string tag, input longint act, input longint expv);
    checks++;
    assert (act === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, act, expv);
    end
  endtask

  task automatic chk_near(input string tag, input real act, input real expv, input real tol);
    bit ok;
    ok = ((act - expv) <= tol) && ((expv - act) <= tol);
    checks++;
    assert (ok === 1'b1) else begin
      errors++;
      $error("FAIL %s observed=%0.1f expected=%0.1f tol=%0.1f", tag, act, expv, tol);
    end
  endtask

  task automatic chk_ang(input string tag, input logic [31:0] act, input logic [31:0] expv,
                         input longint tol);
    logic [31:0] diff;
    longint      d;
    bit          ok;
    diff = act - expv;
    d    = longint'($signed(diff));
    ok   = (d <= tol) && (d >= -tol);
    checks++;
    assert (ok === 1'b1) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h tol=%0d", tag, act, expv, tol);
    end
  endtask

  task automatic check_entry(input exp_t e);
    chk_val("out_valid", longint'(out_valid), longint'(e.valid));
    if (e.valid) begin
      chk_val("out_mode", longint'(out_mode), longint'(e.mode));
      chk_near("Xout", $itor(Xout), e.ex, TOL_XY);
      chk_near("Yout", $itor(Yout), e.ey, TOL_XY);
      chk_ang("Zout", Zout, e.ez, e.ztol);
      $display("out m=%0d X=%0d Y=%0d Z=%08h exp X=%0.1f Y=%0.1f Z=%08h",
               out_mode, Xout, Yout, Zout, e.ex, e.ey, e.ez);
    end
  endtask

  function automatic exp_t model(input bit v, input bit m, input logic [31:0] ang,
                                 input int x, input int y, input longint ztol);
    exp_t   e;
    real    th, a;
    longint zl;
    e.valid = v;
    e.mode  = m;
    e.ztol  = ztol;
    e.ex    = 0.0;
    e.ey    = 0.0;
    e.ez    = '0;
    if (m) begin
      e.ex = gain * $sqrt($itor(x) * $itor(x) + $itor(y) * $itor(y));
      a    = $atan2($itor(y), $itor(x)) * 2147483648.0 / PI;
      zl   = longint'(a);
      if (zl < 0) zl += 64'sd4294967296;
      e.ez = zl[31:0];
    end else begin
      th   = $itor($signed(ang)) * PI / 2147483648.0;
      e.ex = gain * ($itor(x) * $cos(th) - $itor(y) * $sin(th));
      e.ey = gain * ($itor(x) * $sin(th) + $itor(y) * $cos(th));
    end
    return e;
  endfunction

  // One clock: check the sample due now, then drive the next input.
  task automatic step(input bit release_rst, input bit v, input bit expect_out, input bit m,
                      input logic [31:0] ang, input int x, input int y, input longint ztol);
    exp_t e;
    @(negedge clock);
    e = exp_q.pop_front();
    check_entry(e);
    if (release_rst) rst_n = 1'b1;
    in_valid = v;
    mode     = m;
    angle    = ang;
    Xin      = 17'(x);
    Yin      = 17'(y);
    $display("in  v=%0d m=%0d ang=%08h X=%0d Y=%0d", v, m, ang, x, y);
    exp_q.push_back(model(v & expect_out, m, ang, x, y, ztol));
  endtask

  task automatic fill_idle();
    exp_t e;
    e = model(1'b0, 1'b0, 32'h0, 0, 0, 0);
    exp_q.delete();
    for (int i = 0; i < LAT; i++) exp_q.push_back(e);
  endtask

  task automatic rand_step(input bit release_rst, input bit v, input bit expect_out);
    real r, phi;
    int  x, y;
    bit  m;
    r   = $itor($urandom_range(8000, 12000));
    phi = $itor($urandom) * 2.0 * PI / 4294967296.0;
    x   = $rtoi(r * $cos(phi));
    y   = $rtoi(r * $sin(phi));
    m   = 1'($urandom_range(0, 1));
    step(release_rst, v, expect_out, m, $urandom, x, y, 64'd524288);
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    mode     = 1'b0;
    angle    = '0;
    Xin      = '0;
    Yin      = '0;
    gain     = 1.0;
    if (!GAIN_ONE)
      for (int i = 0; i < STG; i++) gain = gain * $sqrt(1.0 + 2.0 ** (-2.0 * i));

    repeat (3) @(negedge clock);
    chk_val("rst out_valid", longint'(out_valid), 0);
    chk_val("rst out_mode", longint'(out_mode), 0);
    chk_val("rst Xout", longint'(Xout), 0);
    chk_val("rst Yout", longint'(Yout), 0);
    chk_val("rst Zout", longint'(Zout), 0);

    fill_idle();
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 0, 0, 0);

    // Directed: every pre-rotation branch
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h2000_0000, 10000, 0, 64'd262144);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h6000_0000, 10000, 0, 64'd262144);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'hA000_0000, 10000, 0, 64'd262144);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'hE000_0000, 0, 10000, 64'd262144);
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'h0, 10000, 10000, 64'd262144);
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'h0, -10000, 0, 64'd262144);
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'h0, -7000, -7000, 64'd262144);
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'h0, 9000, -4000, 64'd262144);

    // Random mixed-mode stream, a bubble in every 5th slot
    begin
      int sent = 0;
      int slot = 0;
      while (sent < 64) begin
        if (slot % 5 == 4) rand_step(1'b0, 1'b0, 1'b0);
        else begin
          rand_step(1'b0, 1'b1, 1'b1);
          sent++;
        end
        slot++;
      end
    end

    // Reset with 10 samples in flight
    for (int i = 0; i < 10; i++) rand_step(1'b0, 1'b1, 1'b1);
    @(negedge clock);
    check_entry(exp_q.pop_front());
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk_val("mid rst out_valid", longint'(out_valid), 0);
    chk_val("mid rst out_mode", longint'(out_mode), 0);
    chk_val("mid rst Xout", longint'(Xout), 0);
    chk_val("mid rst Yout", longint'(Yout), 0);
    chk_val("mid rst Zout", longint'(Zout), 0);
    fill_idle();
    // Sample presented on the release cycle is expected to be dropped
    rand_step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h2000_0000, 10000, 0, 64'd262144);
    for (int i = 0; i < 3; i++) rand_step(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < LAT + 2; i++) rand_step(1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
